// File: rtl/bcd_digit_entry.sv
// bcd_digit_entry: turns debounced key presses into a packed-BCD number and commits it downstream.
// Define BCD_ENTRY_BACKSPACE_EN to add the `del` backspace input.
module bcd_digit_entry #(
  parameter int DIGITS = 4,
  parameter int CW     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [3:0]            key_digit,
  input  logic                  enter,
  input  logic                  clr,
`ifdef BCD_ENTRY_BACKSPACE_EN
  input  logic                  del,
`endif
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  err,
  output logic                  dbg_state
);

  typedef enum logic {
    ENTRY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CW-1:0] MAX_COUNT = CW'(DIGITS);

  state_t              state;
  logic                key_prev;
  logic                press;
  logic                del_req;
  logic [4*DIGITS-1:0] digit_ext;
  logic [4*DIGITS-1:0] shifted;

  always_comb begin
    digit_ext      = '0;
    digit_ext[3:0] = key_digit;
  end

  assign shifted   = (out_bcd << 4) | digit_ext;
  assign press     = key_valid & ~key_prev;
  assign full      = (count == MAX_COUNT);
  assign dbg_state = (state == HOLD);

`ifdef BCD_ENTRY_BACKSPACE_EN
  assign del_req = del;
`else
  assign del_req = 1'b0;
`endif

  // Handshake: out_valid rises one cycle after an accepted enter and stays high with
  // out_bcd/count frozen until a cycle with out_valid & out_ready (or clr) ends the transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ENTRY;
      out_valid <= 1'b0;
      out_bcd   <= '0;
      count     <= '0;
      err       <= 1'b0;
      key_prev  <= 1'b0;
    end else begin
      key_prev <= key_valid;
      case (state)
        ENTRY: begin
          if (clr) begin
            out_bcd <= '0;
            count   <= '0;
            err     <= 1'b0;
          end else if (enter) begin
            if (count != '0) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end else if (del_req) begin
            // A same-cycle press is dropped even when there is nothing to delete.
            if (count != '0) begin
              out_bcd <= out_bcd >> 4;
              count   <= count - CW'(1);
            end
          end else if (press) begin
            if (key_digit > 4'd9 || full) begin
              err <= 1'b1;
            end else begin
              out_bcd <= shifted;
              count   <= count + CW'(1);
            end
          end
        end
        HOLD: begin
          if (clr || out_ready) begin
            state     <= ENTRY;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            count     <= '0;
            if (clr) err <= 1'b0;
          end
        end
        default: begin
          state     <= ENTRY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Bench for bcd_digit_entry: directed test-plan sequences plus randomized traffic
// compared every cycle against a queue-based model of the digit buffer.
module tb_bcd_digit_entry;
  localparam int DIGITS = 4;
  localparam int CW     = 3;
  localparam int W      = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [3:0]    key_digit = 4'd0;
  logic          enter = 1'b0;
  logic          clr = 1'b0;
  logic          del = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_bcd;
  logic [CW-1:0] count;
  logic          full;
  logic          err;
  logic          dbg_state;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  bcd_digit_entry #(.DIGITS(DIGITS), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .enter(enter), .clr(clr),
`ifdef BCD_ENTRY_BACKSPACE_EN
    .del(del),
`endif
    .out_ready(out_ready), .out_valid(out_valid), .out_bcd(out_bcd),
    .count(count), .full(full), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural model: the held number is a queue of digits, oldest first.
  logic [3:0] m_digs[$];
  bit         m_hold = 1'b0;
  bit         m_err = 1'b0;
  bit         m_kprev = 1'b0;

  function automatic logic [W-1:0] model_bcd();
    logic [W-1:0] v = '0;
    foreach (m_digs[i]) v = (v << 4) | W'(m_digs[i]);
    return v;
  endfunction

  always @(posedge clk) begin
    bit p;
    bit d;
    p = key_valid && !m_kprev;
`ifdef BCD_ENTRY_BACKSPACE_EN
    d = del;
`else
    d = 1'b0;
`endif
    if (!rst_n) begin
      m_digs.delete();
      m_hold = 0; m_err = 0; m_kprev = 0;
    end else begin
      m_kprev = key_valid;
      if (m_hold) begin
        if (clr) m_err = 0;
        if (clr || out_ready) begin
          m_digs.delete();
          m_hold = 0;
        end
      end else if (clr) begin
        m_digs.delete();
        m_err = 0;
      end else if (enter) begin
        if (m_digs.size() > 0) m_hold = 1;
      end else if (d) begin
        if (m_digs.size() > 0) void'(m_digs.pop_back());
      end else if (p) begin
        if (key_digit > 9 || m_digs.size() == DIGITS) m_err = 1;
        else m_digs.push_back(key_digit);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model out_valid", 32'(out_valid), 32'(m_hold));
      chk("model out_bcd", 32'(out_bcd), 32'(model_bcd()));
      chk("model count", 32'(count), 32'(m_digs.size()));
      chk("model full", 32'(full), 32'(m_digs.size() == DIGITS));
      chk("model err", 32'(err), 32'(m_err));
      chk("model dbg_state", 32'(dbg_state), 32'(m_hold));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Key held 5 cycles, released for 2.
  task automatic press_key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d;
    cyc(5);
    key_valid = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_clr();
    clr = 1'b1; cyc(1); clr = 1'b0; cyc(1);
  endtask

  initial begin
    cyc(2);
    cmp_en = 1'b1;
    chk("reset out_bcd", 32'(out_bcd), 32'h0);
    chk("reset count", 32'(count), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    press_key(4'd1); chk("count after 1", 32'(count), 32'd1);
    press_key(4'd2); chk("count after 2", 32'(count), 32'd2);
    press_key(4'd3);
    chk("123 out_bcd", 32'(out_bcd), 32'h0123);
    chk("123 count", 32'(count), 32'd3);
    chk("123 full", 32'(full), 32'd0);
    chk("123 err", 32'(err), 32'd0);

    pulse_clr();
    press_key(4'd9); press_key(4'd8); press_key(4'd7); press_key(4'd6);
    chk("9876 full", 32'(full), 32'd1);
    chk("9876 err before overflow", 32'(err), 32'd0);
    press_key(4'd5);
    chk("overflow out_bcd", 32'(out_bcd), 32'h9876);
    chk("overflow err", 32'(err), 32'd1);

    pulse_clr();
    press_key(4'hC);
    chk("bad digit out_bcd", 32'(out_bcd), 32'h0);
    chk("bad digit err", 32'(err), 32'd1);
    pulse_clr();
    chk("clr err", 32'(err), 32'd0);
    chk("clr out_bcd", 32'(out_bcd), 32'h0);

    press_key(4'd4); press_key(4'd2);
    enter = 1'b1; cyc(1); enter = 1'b0;
    chk("enter latency", 32'(out_valid), 32'd1);
    cyc(3);
    chk("hold out_valid", 32'(out_valid), 32'd1);
    chk("hold out_bcd", 32'(out_bcd), 32'h0042);
    press_key(4'd7);
    chk("press in hold", 32'(out_bcd), 32'h0042);
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    chk("handshake out_valid", 32'(out_valid), 32'd0);
    chk("handshake count", 32'(count), 32'd0);

    press_key(4'd1); press_key(4'd2);
    key_valid = 1'b1; key_digit = 4'd3; enter = 1'b1; cyc(1); enter = 1'b0;
    chk("enter+press out_valid", 32'(out_valid), 32'd1);
    chk("enter+press out_bcd", 32'(out_bcd), 32'h0012);
    key_valid = 1'b0;
    out_ready = 1'b1; cyc(1); out_ready = 1'b0;
    enter = 1'b1; cyc(1); enter = 1'b0;
    chk("enter empty", 32'(out_valid), 32'd0);

`ifdef BCD_ENTRY_BACKSPACE_EN
    press_key(4'd5); press_key(4'd6); press_key(4'd7);
    del = 1'b1; cyc(1); del = 1'b0; cyc(1);
    chk("del out_bcd", 32'(out_bcd), 32'h0056);
    chk("del count", 32'(count), 32'd2);
    repeat (3) begin del = 1'b1; cyc(1); del = 1'b0; cyc(1); end
    chk("del empty out_bcd", 32'(out_bcd), 32'h0);
    chk("del empty err", 32'(err), 32'd0);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) key_valid = ~key_valid;
      key_digit = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      enter     = ($urandom_range(0, 11) == 0);
      clr       = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      del       = ($urandom_range(0, 9) == 0);
      cyc(1);
    end
    rst_n = 1'b1; enter = 1'b0; clr = 1'b0; del = 1'b0; key_valid = 1'b0;
    cyc(2);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
